// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate.sv
// Multi-channel gated clock divider.
// Each channel produces a registered 50% duty divided clock of period
// 2*(SH+1) source cycles. It starts one cycle after its run request is seen,
// and it stops only at the end of a high phase, so no runt pulse is ever
// emitted. A new ratio is loaded only at the high-to-low transition.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gate #(
    parameter int NCH  = 2,
    parameter int DIVW = 4
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*DIVW-1:0]  DIV,
    output logic [NCH-1:0]       Z,
    output logic [NCH-1:0]       ACK,
    inout  wire                  VDD,
    inout  wire                  VSS
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The supply pins are physical only. They are collected here so the
    // netlist keeps them without giving them any logic function.
    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t          state_q, state_d;
        logic [DIVW-1:0] cnt_q, cnt_d;
        logic [DIVW-1:0] sh_q, sh_d;
        logic            z_q, z_d;
        logic            ack_q, ack_d;
        logic [DIVW-1:0] div_k;
        logic            phase_end;

        assign div_k     = DIV[k*DIVW +: DIVW];
        assign phase_end = (cnt_q == sh_q);

        // Channel state register; the async reset clears everything,
        // including a period that is only partly done.
        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                sh_q    <= '0;
                z_q     <= 1'b0;
                ack_q   <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments keep every flop sampling the
                // pre-edge values, so the register order inside the block
                // cannot change behaviour.
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sh_q    <= sh_d;
                z_q     <= z_d;
                ack_q   <= ack_d;
            end
        end

        // Next state: start on request, count out each phase, toggle at the
        // phase end, and reload the ratio or stop only on a falling toggle.
        always_comb begin
            // NOTE: every output gets a hold value first; without it, any
            // path that skips an assignment would infer a latch.
            state_d = state_q;
            cnt_d   = cnt_q;
            sh_d    = sh_q;
            z_d     = z_q;
            ack_d   = ack_q;

            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (EN[k]) begin
                        state_d = RUN;
                        z_d     = 1'b1;
                        ack_d   = 1'b1;
                        sh_d    = div_k;
                    end else begin
                        z_d   = 1'b0;
                        ack_d = 1'b0;
                    end
                end
                RUN: begin
                    if (!phase_end) begin
                        cnt_d = cnt_q + DIVW'(1);
                    end else begin
                        cnt_d = '0;
                        z_d   = ~z_q;
                        // A high phase is ending: this is the period
                        // boundary where a new ratio and a stop are allowed.
                        if (z_q) begin
                            sh_d = div_k;
                            if (!EN[k]) begin
                                state_d = IDLE;
                                ack_d   = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        assign Z[k]   = z_q;
        assign ACK[k] = ack_q;
    end

endmodule
